// File: rtl/cordic_pkg.sv
// Shared CORDIC constants and arctangent table (Q2.13), used by the atan2
// vectoring block and reusable by the rotation-mode Sine block.
package cordic_pkg;

  localparam int ANGLE_W = 16;
  localparam int ITER_N  = 16;
  localparam int DP_W    = 18;
  localparam int Z_W     = 17;
  localparam int PI_Q13  = 25736;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } cordic_state_t;

  // atan(2^-i) in Q2.13; the last two entries round to zero.
  function automatic logic signed [Z_W-1:0] atan_lut(input logic [3:0] idx);
    case (idx)
      4'd0:    atan_lut = 17'sd6434;
      4'd1:    atan_lut = 17'sd3798;
      4'd2:    atan_lut = 17'sd2007;
      4'd3:    atan_lut = 17'sd1019;
      4'd4:    atan_lut = 17'sd511;
      4'd5:    atan_lut = 17'sd256;
      4'd6:    atan_lut = 17'sd128;
      4'd7:    atan_lut = 17'sd64;
      4'd8:    atan_lut = 17'sd32;
      4'd9:    atan_lut = 17'sd16;
      4'd10:   atan_lut = 17'sd8;
      4'd11:   atan_lut = 17'sd4;
      4'd12:   atan_lut = 17'sd2;
      4'd13:   atan_lut = 17'sd1;
      default: atan_lut = 17'sd0;
    endcase
  endfunction

endpackage

// File: rtl/cordic_atan2.sv
// Iterative CORDIC vectoring-mode atan2: drives y to zero, accumulates angle in z.
// Optional macro CORDIC_ATAN2_MAG_EN adds the uncompensated magnitude output Mag_o.
//
// state | meaning
// IDLE  | waiting for Start_i; latches and pre-rotates X_i/Y_i
// ITER  | one micro-rotation per clock, 16 in total
// DONE  | one cycle; loads Angle_o (and Mag_o), pulses Done_o on leaving
module cordic_atan2
  import cordic_pkg::*;
(
  input  logic               Clk_i,
  input  logic               Rst_i,
  input  logic [ANGLE_W-1:0] X_i,
  input  logic [ANGLE_W-1:0] Y_i,
  input  logic               Start_i,
  output logic [ANGLE_W-1:0] Angle_o,
  output logic               Done_o,
  output logic               Busy_o
`ifdef CORDIC_ATAN2_MAG_EN
  ,
  output logic [DP_W-1:0]    Mag_o
`endif
);

  localparam logic signed [Z_W-1:0] Z_PI = Z_W'(PI_Q13);
  localparam logic [3:0] ITER_LAST = 4'(ITER_N - 1);

  cordic_state_t state;
  logic [3:0] iter;
  logic signed [DP_W-1:0] x, y;
  logic signed [Z_W-1:0]  z;
  logic zero_in;

  logic signed [DP_W-1:0] x_ext, y_ext, x_in, y_in;
  logic signed [Z_W-1:0]  z_in;
  logic signed [DP_W-1:0] x_sh, y_sh, x_step, y_step;
  logic signed [Z_W-1:0]  z_step;
  logic [ANGLE_W-1:0]     angle_sat;

  // Left half-plane inputs are rotated by pi so the iterations only cover +-pi/2.
  always_comb begin
    x_ext = {{(DP_W-ANGLE_W){X_i[ANGLE_W-1]}}, X_i};
    y_ext = {{(DP_W-ANGLE_W){Y_i[ANGLE_W-1]}}, Y_i};
    if (X_i[ANGLE_W-1]) begin
      x_in = -x_ext;
      y_in = -y_ext;
      z_in = Y_i[ANGLE_W-1] ? -Z_PI : Z_PI;
    end else begin
      x_in = x_ext;
      y_in = y_ext;
      z_in = '0;
    end
  end

  always_comb begin
    x_sh = x >>> iter;
    y_sh = y >>> iter;
    if (y[DP_W-1]) begin
      x_step = x - y_sh;
      y_step = y + x_sh;
      z_step = z - atan_lut(iter);
    end else begin
      x_step = x + y_sh;
      y_step = y - x_sh;
      z_step = z + atan_lut(iter);
    end
  end

  // Residual table error can push z slightly past +-pi; clamp instead of wrapping.
  always_comb begin
    if (zero_in)
      angle_sat = '0;
    else if (z > Z_PI)
      angle_sat = ANGLE_W'(Z_PI);
    else if (z < -Z_PI)
      angle_sat = ANGLE_W'(-Z_PI);
    else
      angle_sat = z[ANGLE_W-1:0];
  end

  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      state   <= IDLE;
      iter    <= '0;
      x       <= '0;
      y       <= '0;
      z       <= '0;
      zero_in <= 1'b0;
      Angle_o <= '0;
      Done_o  <= 1'b0;
      Busy_o  <= 1'b0;
`ifdef CORDIC_ATAN2_MAG_EN
      Mag_o   <= '0;
`endif
    end else begin
      Done_o <= 1'b0;
      case (state)
        IDLE: begin
          // Done_o high means the previous result is still being presented.
          if (Start_i && !Done_o) begin
            x       <= x_in;
            y       <= y_in;
            z       <= z_in;
            zero_in <= (X_i == '0) && (Y_i == '0);
            iter    <= '0;
            Busy_o  <= 1'b1;
            state   <= ITER;
          end
        end
        ITER: begin
          x    <= x_step;
          y    <= y_step;
          z    <= z_step;
          iter <= iter + 4'd1;
          if (iter == ITER_LAST)
            state <= DONE;
        end
        DONE: begin
          Angle_o <= angle_sat;
          Done_o  <= 1'b1;
          Busy_o  <= 1'b0;
`ifdef CORDIC_ATAN2_MAG_EN
          Mag_o   <= x;
`endif
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_atan2.sv
// Self-checking bench for cordic_atan2: real-valued atan2 reference model,
// directed corner cases and randomized back-to-back vectors.
module tb_cordic_atan2;

  logic               Clk_i = 1'b0;
  logic               Rst_i;
  logic signed [15:0] X_i, Y_i;
  logic               Start_i;
  logic [15:0]        Angle_o;
  logic               Done_o, Busy_o;
`ifdef CORDIC_ATAN2_MAG_EN
  logic [17:0]        Mag_o;
`endif

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  logic signed [15:0] tx [0:6] = '{16'sh0000, 16'sh4000, 16'sh4000, 16'sh0000,
                                   16'sh0000, 16'sh8000, 16'shC000};
  logic signed [15:0] ty [0:6] = '{16'sh0000, 16'sh2000, 16'sh4000, 16'sh4000,
                                   16'shC000, 16'sh0000, 16'shFFFF};

  always #5 Clk_i = ~Clk_i;

  cordic_atan2 dut (
    .Clk_i   (Clk_i),
    .Rst_i   (Rst_i),
    .X_i     (X_i),
    .Y_i     (Y_i),
    .Start_i (Start_i),
    .Angle_o (Angle_o),
    .Done_o  (Done_o),
    .Busy_o  (Busy_o)
`ifdef CORDIC_ATAN2_MAG_EN
    ,
    .Mag_o   (Mag_o)
`endif
  );

  always @(negedge Clk_i) if (Done_o === 1'b1) done_cnt++;

  function automatic int ref_angle(input int xv, input int yv);
    real a;
    int r;
    if (xv == 0 && yv == 0) return 0;
    a = $atan2(real'(yv), real'(xv)) * 8192.0;
    r = $rtoi(a >= 0.0 ? a + 0.5 : a - 0.5);
    if (r > 25736) r = 25736;
    if (r < -25736) r = -25736;
    return r;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Issues one request and waits (bounded) for Done_o; lat = -1 on timeout.
  task automatic do_op(input logic signed [15:0] xv, input logic signed [15:0] yv,
                       output logic signed [15:0] ang, output int lat);
    @(negedge Clk_i);
    X_i = xv;
    Y_i = yv;
    Start_i = 1'b1;
    @(negedge Clk_i);
    Start_i = 1'b0;
    lat = -1;
    ang = '0;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      @(negedge Clk_i);
      if (Done_o === 1'b1) begin
        lat = c;
        ang = Angle_o;
      end
    end
  endtask

  task automatic test_reset();
    Rst_i = 1'b1;
    Start_i = 1'b1;
    X_i = 16'sh4000;
    Y_i = 16'sh2000;
    repeat (3) @(negedge Clk_i);
    checks++; if (Angle_o !== 16'h0000) begin errors++; $display("FAIL reset_angle: got %0d expected 0", Angle_o); end
    checks++; if (Done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", Done_o); end
    checks++; if (Busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy_with_start: got %b expected 0", Busy_o); end
`ifdef CORDIC_ATAN2_MAG_EN
    checks++; if (Mag_o !== 18'd0) begin errors++; $display("FAIL reset_mag: got %0d expected 0", Mag_o); end
`endif
    Rst_i = 1'b0;
    Start_i = 1'b0;
    @(negedge Clk_i);
    checks++; if (Busy_o !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b expected 0", Busy_o); end
  endtask

  task automatic test_directed();
    logic signed [15:0] ang;
    int lat, exp_a, tol;
    for (int k = 0; k < 7; k++) begin
      do_op(tx[k], ty[k], ang, lat);
      exp_a = ref_angle(int'(tx[k]), int'(ty[k]));
      tol = (tx[k] == 0 && ty[k] == 0) ? 0 : 3;
      checks++;
      if (lat != 17) begin errors++; $display("FAIL directed_latency[%0d]: got %0d expected 17", k, lat); end
      checks++;
      if (iabs(int'(ang) - exp_a) > tol)
        begin errors++; $display("FAIL directed_angle[%0d] X=%0d Y=%0d: got %0d expected %0d +-%0d", k, tx[k], ty[k], ang, exp_a, tol); end
    end
  endtask

  task automatic test_latency();
    logic [15:0] prev, ang;
    int bad;
    prev = Angle_o;
    ang = '0;
    bad = 0;
    @(negedge Clk_i);
    X_i = 16'sh2000;
    Y_i = 16'shE000;
    Start_i = 1'b1;
    @(negedge Clk_i);
    Start_i = 1'b0;
    for (int c = 0; c <= 18; c++) begin
      if (c > 0) @(negedge Clk_i);
      if (c <= 16 && (Busy_o !== 1'b1 || Done_o !== 1'b0)) bad++;
      if (c == 10) begin
        checks++; if (Angle_o !== prev) begin errors++; $display("FAIL hold_mid_iter: got %0d expected %0d", Angle_o, prev); end
      end
      if (c == 17) begin
        ang = Angle_o;
        checks++; if (Done_o !== 1'b1 || Busy_o !== 1'b0)
          begin errors++; $display("FAIL done_cycle: got done=%b busy=%b expected done=1 busy=0", Done_o, Busy_o); end
      end
      if (c == 18) begin
        checks++; if (Done_o !== 1'b0) begin errors++; $display("FAIL done_one_cycle: got %b expected 0", Done_o); end
      end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL busy_window: got %0d bad cycles expected 0", bad); end
    checks++; if (iabs(int'($signed(ang)) - ref_angle(8192, -8192)) > 3)
      begin errors++; $display("FAIL latency_angle: got %0d expected %0d", $signed(ang), ref_angle(8192, -8192)); end
  endtask

  task automatic test_busy_ignore();
    logic [15:0] ang;
    int d0, exp_a;
    d0 = done_cnt;
    ang = '0;
    exp_a = ref_angle(16384, 16384);
    @(negedge Clk_i);
    X_i = 16'sh4000;
    Y_i = 16'sh4000;
    Start_i = 1'b1;
    @(negedge Clk_i);
    Start_i = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge Clk_i);
      Start_i = 1'b0;
      if (c == 5) begin X_i = 16'sh0000; Y_i = 16'sh7000; Start_i = 1'b1; end
      if (c == 17) begin ang = Angle_o; Start_i = 1'b1; end
    end
    @(negedge Clk_i);
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL busy_single_done: got %0d expected 1", done_cnt - d0); end
    checks++; if (iabs(int'($signed(ang)) - exp_a) > 3)
      begin errors++; $display("FAIL busy_angle: got %0d expected %0d", $signed(ang), exp_a); end
    checks++; if (Busy_o !== 1'b0) begin errors++; $display("FAIL start_during_done_ignored: got busy=%b expected 0", Busy_o); end
    checks++; if (Angle_o !== ang) begin errors++; $display("FAIL angle_hold: got %0d expected %0d", Angle_o, ang); end
  endtask

  task automatic test_reset_mid();
    logic signed [15:0] ang;
    int lat, d0, exp_a;
    @(negedge Clk_i);
    X_i = 16'sh2000;
    Y_i = 16'sh6000;
    Start_i = 1'b1;
    @(negedge Clk_i);
    Start_i = 1'b0;
    repeat (8) @(negedge Clk_i);
    Rst_i = 1'b1;
    @(negedge Clk_i);
    Rst_i = 1'b0;
    checks++; if (Angle_o !== 16'h0000) begin errors++; $display("FAIL midreset_angle: got %0d expected 0", Angle_o); end
    checks++; if (Busy_o !== 1'b0 || Done_o !== 1'b0)
      begin errors++; $display("FAIL midreset_flags: got busy=%b done=%b expected 0 0", Busy_o, Done_o); end
    d0 = done_cnt;
    exp_a = ref_angle(24576, -8192);
    do_op(16'sh6000, 16'shE000, ang, lat);
    repeat (3) @(negedge Clk_i);
    checks++; if (lat != 17) begin errors++; $display("FAIL midreset_restart_latency: got %0d expected 17", lat); end
    checks++; if (iabs(int'(ang) - exp_a) > 3)
      begin errors++; $display("FAIL midreset_restart_angle: got %0d expected %0d", ang, exp_a); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL midreset_done_count: got %0d expected 1", done_cnt - d0); end
  endtask

  task automatic test_random();
    logic signed [15:0] xv, yv, ang;
    int big, other, lat, exp_a;
    for (int n = 0; n < 40; n++) begin
      big = int'($urandom_range(32767, 24576));
      if ($urandom_range(1, 0) == 1) big = -big;
      other = int'($urandom_range(65535, 0)) - 32768;
      if ($urandom_range(1, 0) == 1) begin xv = 16'(big); yv = 16'(other); end
      else begin xv = 16'(other); yv = 16'(big); end
      exp_a = ref_angle(int'(xv), int'(yv));
      do_op(xv, yv, ang, lat);
      checks++;
      if (lat != 17) begin errors++; $display("FAIL random_latency[%0d]: got %0d expected 17", n, lat); end
      checks++;
      if (iabs(int'(ang) - exp_a) > 3)
        begin errors++; $display("FAIL random_angle[%0d] X=%0d Y=%0d: got %0d expected %0d", n, xv, yv, ang, exp_a); end
    end
  endtask

`ifdef CORDIC_ATAN2_MAG_EN
  task automatic test_mag();
    logic signed [15:0] ang;
    int lat, exp_m;
    exp_m = $rtoi($sqrt(16384.0 * 16384.0) * 1.6468 + 0.5);
    do_op(16'sh4000, 16'sh0000, ang, lat);
    checks++; if (iabs(int'(Mag_o) - exp_m) > 4)
      begin errors++; $display("FAIL mag_value: got %0d expected %0d +-4", Mag_o, exp_m); end
    repeat (5) @(negedge Clk_i);
    checks++; if (iabs(int'(Mag_o) - exp_m) > 4)
      begin errors++; $display("FAIL mag_hold: got %0d expected %0d +-4", Mag_o, exp_m); end
  endtask
`endif

  initial begin
    Rst_i = 1'b1;
    Start_i = 1'b0;
    X_i = '0;
    Y_i = '0;
    test_reset();
    test_directed();
    test_latency();
    test_busy_ignore();
    test_reset_mid();
    test_random();
`ifdef CORDIC_ATAN2_MAG_EN
    test_mag();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
